// File: rtl/result_drain.sv
// Drains result words from the FIFO into SRAM, two bus words per result; optional RESULT_DRAIN_CHECKSUM_EN adds an XOR trailer.
// Latency: start->rdreq 1 cycle, 4 cycles per result word; done one cycle after the terminating FETCH.
// Backpressure: waitrequest holds write/address/data/byteenable and adds exactly one cycle per stalled cycle.
module result_drain #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RTF_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_max_words,
    output logic                  o_rfifo_rdreq,
    input  logic [RTF_WIDTH-1:0]  i_rfifo_dataq,
    input  logic                  i_rfifo_rdempty,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [BE_WIDTH-1:0]   o_byteenable,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_writedata,
    input  logic                  i_waitrequest,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
`ifdef RESULT_DRAIN_CHECKSUM_EN
    output logic [RTF_WIDTH-1:0]  o_checksum,
`endif
    output logic [CNT_WIDTH-1:0]  o_word_count
);

    localparam int HI_BYTES = (RTF_WIDTH - DATA_WIDTH + 7) / 8;
    localparam logic [BE_WIDTH-1:0] BE_ALL = '1;
    localparam logic [BE_WIDTH-1:0] BE_HI  = BE_ALL >> (BE_WIDTH - HI_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WR_LO,
        S_WR_HI,
        S_FIN
`ifdef RESULT_DRAIN_CHECKSUM_EN
        , S_TRL_LO
        , S_TRL_HI
`endif
    } state_t;

`ifdef RESULT_DRAIN_CHECKSUM_EN
    localparam state_t S_TERM = S_TRL_LO;
`else
    localparam state_t S_TERM = S_FIN;
`endif

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [CNT_WIDTH-1:0]    r_limit;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    r_overflow;
    logic [RTF_WIDTH-1:0]    r_hold;
    logic [2*DATA_WIDTH-1:0] w_hold_ext;
    logic                    w_start_acc;
    logic                    w_at_limit;
    logic                    w_wr_acc;

    assign w_start_acc = i_start && (r_state == S_IDLE || r_state == S_FIN);
    assign w_at_limit  = (r_count == r_limit);
    assign w_wr_acc    = o_write && !i_waitrequest;
    assign w_hold_ext  = (2*DATA_WIDTH)'(r_hold);

`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [RTF_WIDTH-1:0]    r_checksum;
    logic [2*DATA_WIDTH-1:0] w_sum_ext;
    assign w_sum_ext  = (2*DATA_WIDTH)'(r_checksum);
    assign o_checksum = r_checksum;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_FIN: if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                if (w_at_limit)            w_next = S_TERM;
                else if (!i_rfifo_rdempty) w_next = S_LATCH;
                else if (i_flush)          w_next = S_TERM;
            end
            S_LATCH:  w_next = S_WR_LO;
            S_WR_LO:  if (w_wr_acc) w_next = S_WR_HI;
            S_WR_HI:  if (w_wr_acc) w_next = S_FETCH;
`ifdef RESULT_DRAIN_CHECKSUM_EN
            S_TRL_LO: if (w_wr_acc) w_next = S_TRL_HI;
            S_TRL_HI: if (w_wr_acc) w_next = S_FIN;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so a stall holds them with no extra registers.
    always_comb begin
        o_rfifo_rdreq = 1'b0;
        o_write       = 1'b0;
        o_writedata   = '0;
        o_byteenable  = '0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                o_busy        = 1'b1;
                o_rfifo_rdreq = !w_at_limit && !i_rfifo_rdempty;
            end
            S_LATCH: o_busy = 1'b1;
            S_WR_LO: begin
                o_busy       = 1'b1;
                o_write      = 1'b1;
                o_writedata  = w_hold_ext[DATA_WIDTH-1:0];
                o_byteenable = BE_ALL;
            end
            S_WR_HI: begin
                o_busy       = 1'b1;
                o_write      = 1'b1;
                o_writedata  = w_hold_ext[2*DATA_WIDTH-1:DATA_WIDTH];
                o_byteenable = BE_HI;
            end
`ifdef RESULT_DRAIN_CHECKSUM_EN
            S_TRL_LO: begin
                o_busy       = 1'b1;
                o_write      = 1'b1;
                o_writedata  = w_sum_ext[DATA_WIDTH-1:0];
                o_byteenable = BE_ALL;
            end
            S_TRL_HI: begin
                o_busy       = 1'b1;
                o_write      = 1'b1;
                o_writedata  = w_sum_ext[2*DATA_WIDTH-1:DATA_WIDTH];
                o_byteenable = BE_HI;
            end
`endif
            S_FIN:   o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_limit    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_hold     <= '0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
            r_checksum <= '0;
`endif
        end else begin
            if (w_start_acc) begin
                r_addr     <= i_base_addr;
                r_limit    <= i_max_words;
                r_count    <= '0;
                r_overflow <= 1'b0;
`ifdef RESULT_DRAIN_CHECKSUM_EN
                r_checksum <= '0;
`endif
            end
            if (r_state == S_FETCH && w_at_limit) begin
                r_overflow <= !i_rfifo_rdempty;
            end
            if (r_state == S_LATCH) begin
                r_hold     <= i_rfifo_dataq;
`ifdef RESULT_DRAIN_CHECKSUM_EN
                r_checksum <= r_checksum ^ i_rfifo_dataq;
`endif
            end
            // Address wraps modulo 2^ADDR_WIDTH by design.
            if (w_wr_acc) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
            if (w_wr_acc && r_state == S_WR_HI) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_address    = r_addr;
    assign o_overflow   = r_overflow;
    assign o_word_count = r_count;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: FIFO and memory-bus models driven at negedge, results checked against a per-run reference list.
module tb_result_drain;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [19:0] base_addr;
    logic [15:0] max_words;
    logic        rfifo_rdreq;
    logic [23:0] rfifo_dataq;
    logic        rfifo_rdempty;
    logic [19:0] address;
    logic [1:0]  byteenable;
    logic        write;
    logic [15:0] writedata;
    logic        waitrequest;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] word_count;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [23:0] checksum;
    localparam int TRL = 2;
`else
    localparam int TRL = 0;
`endif

    result_drain dut (
        .i_clock         (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_flush         (flush),
        .i_base_addr     (base_addr),
        .i_max_words     (max_words),
        .o_rfifo_rdreq   (rfifo_rdreq),
        .i_rfifo_dataq   (rfifo_dataq),
        .i_rfifo_rdempty (rfifo_rdempty),
        .o_address       (address),
        .o_byteenable    (byteenable),
        .o_write         (write),
        .o_writedata     (writedata),
        .i_waitrequest   (waitrequest),
        .o_busy          (busy),
        .o_done          (done),
        .o_overflow      (overflow),
`ifdef RESULT_DRAIN_CHECKSUM_EN
        .o_checksum      (checksum),
`endif
        .o_word_count    (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    logic [23:0] q[$];
    logic [23:0] wl[$];
    wr_t         got[$];
    wr_t         prev_wr;
    bit          prev_stall;
    bit          pend_pop;
    bit          trickle;
    bit          go;
    int          pushed;
    int          stall_pct;
    int          st_from;
    int          st_len;
    int          k;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later (well before the next rising edge).
    task automatic step();
        wr_t cur;
        @(negedge clk);
        start = go && (k == 0);
        if (pend_pop) begin
            rfifo_dataq = q.pop_front();
            pend_pop = 0;
        end
        if (trickle && pushed < wl.size() && $urandom_range(0, 2) == 0) begin
            q.push_back(wl[pushed]);
            pushed++;
        end
        if (trickle && pushed == wl.size()) flush = 1'b1;
        rfifo_rdempty = (q.size() == 0);
        waitrequest = (k >= st_from && k < st_from + st_len) ||
                      ($urandom_range(0, 99) < stall_pct);
        #1;
        cur = '{address, writedata, byteenable};
        if (rfifo_rdreq) begin
            chk("rdreq_while_empty", rfifo_rdempty, 1'b0);
            pend_pop = !rfifo_rdempty;
        end
        if (prev_stall) chk("stall_hold", {write, cur}, {1'b1, prev_wr});
        prev_stall = write && waitrequest;
        prev_wr    = cur;
        if (write && !waitrequest) got.push_back(cur);
        k++;
    endtask

    // Full drain run of the words in wl; expected writes built from the packing rules.
    task automatic run(input logic [19:0] base, input logic [15:0] mw, input bit trk,
                       input int spct, input int sfrom, input int slen, input int exp_cyc);
        wr_t         exp_q[$];
        logic [19:0] a;
        logic [23:0] x;
        int          n, d, fin_at;
        n = wl.size();
        d = (n < int'(mw)) ? n : int'(mw);
        q.delete(); got.delete();
        pend_pop = 0; prev_stall = 0; flush = 1'b0; trickle = trk; pushed = 0;
        stall_pct = spct; st_from = sfrom; st_len = slen;
        base_addr = base; max_words = mw;
        if (!trk) begin
            foreach (wl[i]) q.push_back(wl[i]);
            pushed = n;
            flush = 1'b1;
        end
        k = 0; go = 1; fin_at = -1;
        step();
        step();
        chk("busy_after_start", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
        while (fin_at < 0 && k < 3000) begin
            step();
            if (done) fin_at = k - 1;
        end
        go = 0;
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        a = base; x = '0;
        for (int i = 0; i < d; i++) begin
            exp_q.push_back('{a, wl[i][15:0], 2'b11});
            a = a + 20'd1;
            exp_q.push_back('{a, {8'h00, wl[i][23:16]}, 2'b01});
            a = a + 20'd1;
            x = x ^ wl[i];
        end
`ifdef RESULT_DRAIN_CHECKSUM_EN
        exp_q.push_back('{a, x[15:0], 2'b11});
        a = a + 20'd1;
        exp_q.push_back('{a, {8'h00, x[23:16]}, 2'b01});
        chk("checksum", checksum, x);
`endif
        chk("write_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("write_rec", got[i], exp_q[i]);
        chk("word_count", word_count, d);
        chk("overflow", overflow, n > int'(mw));
        chk("fifo_left", q.size(), n - d);
        if (exp_cyc >= 0) chk("done_cycle", fin_at, exp_cyc);
    endtask

    initial begin
        clk = 0; reset = 1'b1; start = 1'b0; flush = 1'b0; go = 0; k = 0;
        base_addr = '0; max_words = '0; rfifo_dataq = '0; rfifo_rdempty = 1'b1;
        waitrequest = 1'b0; st_from = -1; st_len = 0; stall_pct = 0; trickle = 0;
        checks = 0; errors = 0; pushed = 0; pend_pop = 0; prev_stall = 0;
        repeat (3) step();
        chk("rst_outs", {rfifo_rdreq, write, address, byteenable, writedata, busy, done, overflow, word_count}, '0);
        reset = 1'b0;

        // Basic two-word drain ended by flush.
        wl.delete(); wl.push_back(24'h123456); wl.push_back(24'hABCDEF);
        run(20'h00100, 16'd4, 0, 0, -1, 0, 10 + TRL);
        chk("wr0", got[0], {20'h00100, 16'h3456, 2'b11});
        chk("wr1", got[1], {20'h00101, 16'h0012, 2'b01});
        chk("wr3", got[3], {20'h00103, 16'h00AB, 2'b01});

        // Three stall cycles on the first WR_HI.
        run(20'h00100, 16'd4, 0, 0, 4, 3, 13 + TRL);

        // Limit reached with data still queued.
        wl.delete(); wl.push_back(24'h111111); wl.push_back(24'h222222); wl.push_back(24'h333333);
        run(20'h00400, 16'd2, 0, 0, -1, 0, 10 + TRL);

        // Zero limit: no read, no data write.
        wl.delete(); wl.push_back(24'h0000AA); wl.push_back(24'h0000BB);
        run(20'h00500, 16'd0, 0, 0, -1, 0, 2 + TRL);

        // Address wrap at the top of memory.
        wl.delete(); wl.push_back(24'hFEDCBA); wl.push_back(24'h010203);
        run(20'hFFFFE, 16'd2, 0, 0, -1, 0, 10 + TRL);

        // Checksum pattern.
        wl.delete(); wl.push_back(24'h0000FF); wl.push_back(24'h00FF00);
        run(20'h00300, 16'd4, 0, 0, -1, 0, 10 + TRL);
`ifdef RESULT_DRAIN_CHECKSUM_EN
        chk("trailer_lo", got[4], {20'h00304, 16'hFFFF, 2'b11});
        chk("trailer_hi", got[5], {20'h00305, 16'h0000, 2'b01});
`endif

        // Reset while in WR_LO aborts the run.
        q.delete(); got.delete(); q.push_back(24'h5A5A5A);
        flush = 1'b1; trickle = 0; stall_pct = 0; st_from = -1; st_len = 0;
        pend_pop = 0; prev_stall = 0; base_addr = 20'h00200; max_words = 16'd4;
        k = 0; go = 1;
        repeat (4) step();
        go = 0;
        chk("in_wr_lo", {write, address, byteenable}, {1'b1, 20'h00200, 2'b11});
        reset = 1'b1;
        step();
        chk("abort_outs", {rfifo_rdreq, write, address, byteenable, writedata, busy, done, overflow, word_count}, '0);
        reset = 1'b0;
        wl.delete(); wl.push_back(24'hC0FFEE);
        run(20'h00600, 16'd3, 0, 0, -1, 0, 6 + TRL);

        // Randomized runs with trickled producer and random stalls.
        for (int r = 0; r < 30; r++) begin
            int n, mw;
            bit trk;
            n  = $urandom_range(0, 6);
            mw = $urandom_range(0, 7);
            wl.delete();
            for (int i = 0; i < n; i++) wl.push_back(24'($urandom));
            trk = (n <= mw) ? bit'($urandom_range(0, 1)) : 1'b0;
            run(20'($urandom), 16'(mw), trk, $urandom_range(0, 40), -1, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
